// File: rtl/nunchuck_pkg.sv
// nunchuck_pkg: shared types and constants for the nunchuck I2C responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. The snapshot packing function is shared with the driver-side checks.
package nunchuck_pkg;

    localparam logic [6:0] NC_ADDR      = 7'h52;
    localparam logic [7:0] NC_REG_INIT1 = 8'hF0;
    localparam logic [7:0] NC_VAL_INIT1 = 8'h55;
    localparam logic [7:0] NC_REG_INIT2 = 8'hFB;
    localparam logic [7:0] NC_VAL_INIT2 = 8'h00;
    localparam int         NC_NUM_BYTES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } nc_state_t;

    // Byte i of the report sits at bits [8*i +: 8]. Buttons are active-low on the bus.
    function automatic logic [NC_NUM_BYTES*8-1:0] nc_pack_snapshot(
        input logic [7:0] sx,
        input logic [7:0] sy,
        input logic [9:0] ax,
        input logic [9:0] ay,
        input logic [9:0] az,
        input logic       bz,
        input logic       bc
    );
        nc_pack_snapshot = {{az[1:0], ay[1:0], ax[1:0], ~bc, ~bz},
                            az[9:2], ay[9:2], ax[9:2], sy, sx};
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes SCL/SDA and flags SCL edges plus START/STOP.
// Latency: SYNC_STAGES+1 clk from a pin change to the matching one-cycle pulse.
// Backpressure: none; pure observer, never drives the bus.
// Ports: i_clk/i_rst (sync, active-high); i_scl/i_sda raw pins; o_sda synced SDA level;
//        o_scl_rise/o_scl_fall/o_start/o_stop single-cycle pulses.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Idle bus is high on both lines, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    // SDA may only move while SCL is low; any SDA edge with SCL held high is a bus condition.
    assign o_start    = w_scl & r_scl_prev & ~w_sda & r_sda_prev;
    assign o_stop     = w_scl & r_scl_prev & w_sda & ~r_sda_prev;

endmodule

// File: rtl/nunchuck_responder.sv
// nunchuck_responder: I2C target at ADDR emulating a Wii nunchuck (init writes, pointer, 6-byte reads).
// Latency: SDA updated SYNC_STAGES+2 clk after the true SCL fall; bits sampled on detected SCL rise.
// Backpressure: none; never stretches SCL, always ACKs writes once addressed.
// Ports: clk, rst (sync active-high); scl in; sda open-drain inout; stick/accel/button inputs;
//        init_done, busy (FSM not idle), conv_strobe (one-cycle snapshot pulse).
// Build option: NUNCHUCK_INIT_CHECK_EN - reads return 0xFF and conversions are ignored until init_done.
module nunchuck_responder
    import nunchuck_pkg::*;
#(
    parameter logic [6:0] ADDR        = NC_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic [9:0] accel_x,
    input  logic [9:0] accel_y,
    input  logic [9:0] accel_z,
    input  logic       z,
    input  logic       c,
    output logic       init_done,
    output logic       busy,
    output logic       conv_strobe
);

    localparam int SNAP_W = NC_NUM_BYTES * 8;

    logic w_sda_lvl, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_mon (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda      (w_sda_lvl),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    nc_state_t         r_state,     w_state_nxt;
    logic [7:0]        r_shift,     w_shift_nxt;
    logic [2:0]        r_bitcnt,    w_bitcnt_nxt;
    logic [7:0]        r_ptr,       w_ptr_nxt;
    logic              r_ptr_load,  w_ptr_load_nxt;
    logic              r_rw,        w_rw_nxt;
    logic              r_init1,     w_init1_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic [SNAP_W-1:0] r_snap,      w_snap_nxt;
    logic              r_sda_oe,    w_sda_oe_nxt;
    logic              r_conv,      w_conv_nxt;
    logic [7:0]        w_shift_in;
    logic [7:0]        w_rd_byte;
    logic              w_gate_ok;

`ifdef NUNCHUCK_INIT_CHECK_EN
    assign w_gate_ok = r_init_done;
`else
    assign w_gate_ok = 1'b1;
`endif

    assign w_shift_in = {r_shift[6:0], w_sda_lvl};

    always_comb begin
        w_rd_byte = 8'hFF;
        if (w_gate_ok && (r_ptr < 8'(NC_NUM_BYTES))) begin
            w_rd_byte = r_snap[{r_ptr[2:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_ptr       <= 8'h00;
            r_ptr_load  <= 1'b0;
            r_rw        <= 1'b0;
            r_init1     <= 1'b0;
            r_init_done <= 1'b0;
            r_snap      <= '1;
            r_sda_oe    <= 1'b0;
            r_conv      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_ptr_load  <= w_ptr_load_nxt;
            r_rw        <= w_rw_nxt;
            r_init1     <= w_init1_nxt;
            r_init_done <= w_init_done_nxt;
            r_snap      <= w_snap_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_conv      <= w_conv_nxt;
        end
    end

    // State changes on SCL rise (sampling); SDA changes only on SCL fall, except START/STOP release.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bitcnt_nxt    = r_bitcnt;
        w_ptr_nxt       = r_ptr;
        w_ptr_load_nxt  = r_ptr_load;
        w_rw_nxt        = r_rw;
        w_init1_nxt     = r_init1;
        w_init_done_nxt = r_init_done;
        w_snap_nxt      = r_snap;
        w_sda_oe_nxt    = r_sda_oe;
        w_conv_nxt      = 1'b0;

        if (w_start) begin
            w_state_nxt  = ST_ADDR;
            w_bitcnt_nxt = 3'd0;
            w_sda_oe_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_shift_in;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_rw_nxt    = w_shift_in[0];
                            w_state_nxt = (w_shift_in[7:1] == ADDR) ? ST_ADDR_ACK : ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b1;
                    end else if (w_scl_rise) begin
                        w_bitcnt_nxt = 3'd0;
                        if (r_rw) begin
                            w_state_nxt = ST_RD_DATA;
                        end else begin
                            w_state_nxt    = ST_WR_DATA;
                            w_ptr_load_nxt = 1'b1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        w_shift_nxt  = w_shift_in;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_state_nxt = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b1;
                    end else if (w_scl_rise) begin
                        // Byte is acted on at the ACK clock so conv_strobe lines up with it.
                        w_bitcnt_nxt = 3'd0;
                        w_state_nxt  = ST_WR_DATA;
                        if (r_ptr_load) begin
                            w_ptr_load_nxt = 1'b0;
                            w_ptr_nxt      = r_shift;
                            if ((r_shift == 8'h00) && w_gate_ok) begin
                                w_snap_nxt = nc_pack_snapshot(stick_x, stick_y, accel_x,
                                                              accel_y, accel_z, z, c);
                                w_conv_nxt = 1'b1;
                            end
                        end else begin
                            if ((r_ptr == NC_REG_INIT1) && (r_shift == NC_VAL_INIT1)) begin
                                w_init1_nxt = 1'b1;
                            end
                            if ((r_ptr == NC_REG_INIT2) && (r_shift == NC_VAL_INIT2) && r_init1) begin
                                w_init_done_nxt = 1'b1;
                            end
                            w_ptr_nxt = r_ptr + 8'd1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = ~w_rd_byte[3'd7 - r_bitcnt];
                    end else if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_state_nxt = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        if (!w_sda_lvl) begin
                            w_ptr_nxt    = r_ptr + 8'd1;
                            w_bitcnt_nxt = 3'd0;
                            w_state_nxt  = ST_RD_DATA;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sda         = r_sda_oe ? 1'b0 : 1'bz;
    assign init_done   = r_init_done;
    assign busy        = (r_state != ST_IDLE);
    assign conv_strobe = r_conv;

endmodule

// File: tb/tb_nunchuck_responder.sv
// tb_nunchuck_responder: bus-level I2C master driving the nunchuck responder with directed vectors.
// Expected values are pushed into a scoreboard queue ahead of each transaction; a monitor process
// pops and compares them as the observed responses (ACK bits, read bytes, status) arrive.
module tb_nunchuck_responder;

    localparam int QTR = 110;
`ifdef NUNCHUCK_INIT_CHECK_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    localparam logic [7:0] T1_EXP   [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h91};
    localparam logic [7:0] PLAN_EXP [8] = '{8'h80, 8'h7F, 8'hA9, 8'h40, 8'hFF, 8'hC6, 8'hFF, 8'hFF};

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_oe;
    wire        sda;
    logic [7:0] stick_x, stick_y;
    logic [9:0] accel_x, accel_y, accel_z;
    logic       z, c;
    logic       init_done, busy, conv_strobe;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    nunchuck_responder dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl),
        .sda         (sda),
        .stick_x     (stick_x),
        .stick_y     (stick_y),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .z           (z),
        .c           (c),
        .init_done   (init_done),
        .busy        (busy),
        .conv_strobe (conv_strobe)
    );

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] act_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_strobe = 0;
    int         n_low    = 0;
    bit         watch_low = 1'b0;
    bit         tb_done   = 1'b0;
    bit         mon_done  = 1'b0;

    always @(negedge clk) if (conv_strobe === 1'b1) n_strobe <= n_strobe + 1;
    always @(negedge clk) if (watch_low && !m_oe && (sda === 1'b0)) n_low <= n_low + 1;

    initial begin : monitor
        logic [7:0] a, e;
        string      nm;
        while (!mon_done) begin
            @(negedge clk);
            while (act_q.size() != 0) begin
                a = act_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output actual=%02h required=none", a);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL %s actual=%02h required=%02h", nm, a, e);
                    end
                end
            end
            if (tb_done) begin
                while (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s actual=none required=%02h", nm, e);
                end
                mon_done = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic expect8(input string nm, input logic [7:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic observe(input logic [7:0] v);
        act_q.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] e, input logic [7:0] a);
        expect8(nm, e);
        observe(a);
    endtask

    task automatic i2c_start();
        m_oe = 1'b0; #QTR;
        scl  = 1'b1; #QTR;
        m_oe = 1'b1; #QTR;
        scl  = 1'b0; #QTR;
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; #QTR;
        scl  = 1'b1; #QTR;
        m_oe = 1'b0; #QTR;
    endtask

    task automatic send_bit(input logic b);
        m_oe = ~b; #QTR;
        scl  = 1'b1; #(2*QTR);
        scl  = 1'b0; #QTR;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_oe = 1'b0; #QTR;
        scl  = 1'b1; #QTR;
        ack  = sda;  #QTR;
        scl  = 1'b0; #QTR;
    endtask

    task automatic read_byte(input bit do_ack, output logic [7:0] b);
        b    = 8'h00;
        m_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #QTR; scl = 1'b1;
            #QTR; b = {b[6:0], sda};
            #QTR; scl = 1'b0;
            #QTR;
        end
        m_oe = do_ack; #QTR;
        scl  = 1'b1;   #(2*QTR);
        scl  = 1'b0;   #QTR;
        m_oe = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [7:0] b, input logic exp_ack);
        logic ack;
        expect8(nm, {7'd0, exp_ack});
        write_byte(b, ack);
        observe({7'd0, ack});
    endtask

    task automatic rd(input string nm, input logic [7:0] e, input bit do_ack);
        logic [7:0] b;
        expect8(nm, e);
        read_byte(do_ack, b);
        observe(b);
    endtask

    task automatic set_plan();
        stick_x = 8'h80;   stick_y = 8'h7F;
        accel_x = 10'h2A5; accel_y = 10'h100; accel_z = 10'h3FF;
        z = 1'b1; c = 1'b0;
    endtask

    initial begin : main
        int s0;
        rst = 1'b1; scl = 1'b1; m_oe = 1'b0;
        stick_x = 8'h01;   stick_y = 8'h02;
        accel_x = 10'h00C; accel_y = 10'h011; accel_z = 10'h016;
        z = 1'b0; c = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_busy",      8'h00, {7'd0, busy});
        chk("reset_init_done", 8'h00, {7'd0, init_done});
        chk("reset_strobe",    8'h00, {7'd0, conv_strobe});
        chk("reset_sda",       8'h01, {7'd0, sda});
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);

        // Conversion and read before init: gated build must ignore both.
        i2c_start(); wr("t1_addr_ack", 8'hA4, 1'b0); wr("t1_ptr_ack", 8'h00, 1'b0); i2c_stop();
        chk("t1_strobes", GATED ? 8'd0 : 8'd1, 8'(n_strobe));
        i2c_start(); wr("t1_rdaddr_ack", 8'hA5, 1'b0);
        for (int i = 0; i < 6; i++) rd($sformatf("t1_rd%0d", i), GATED ? 8'hFF : T1_EXP[i], i != 5);
        i2c_stop();
        chk("t1_init_done", 8'h00, {7'd0, init_done});

        // Init sequence.
        i2c_start(); wr("t2_a", 8'hA4, 1'b0); wr("t2_r1", 8'hF0, 1'b0); wr("t2_v1", 8'h55, 1'b0); i2c_stop();
        chk("t2_init_half", 8'h00, {7'd0, init_done});
        i2c_start(); wr("t2_b", 8'hA4, 1'b0); wr("t2_r2", 8'hFB, 1'b0); wr("t2_v2", 8'h00, 1'b0);
        chk("t2_init_done", 8'h01, {7'd0, init_done});
        i2c_stop();

        // Main conversion; inputs changed afterwards must not leak into the read.
        set_plan();
        s0 = n_strobe;
        i2c_start(); wr("t3_a", 8'hA4, 1'b0); wr("t3_p", 8'h00, 1'b0); i2c_stop();
        chk("t3_strobe_once", 8'd1, 8'(n_strobe - s0));
        stick_x = 8'h11; accel_x = 10'h000; z = 1'b0; c = 1'b1;
        i2c_start(); wr("t3_ra", 8'hA5, 1'b0);
        for (int i = 0; i < 6; i++) rd($sformatf("t3_rd%0d", i), PLAN_EXP[i], i != 5);
        i2c_stop();

        // Eight-byte read past the report, final NACK.
        set_plan();
        i2c_start(); wr("t4_a", 8'hA4, 1'b0); wr("t4_p", 8'h00, 1'b0); i2c_stop();
        i2c_start(); wr("t4_ra", 8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) rd($sformatf("t4_rd%0d", i), PLAN_EXP[i], i != 7);
        repeat (4) @(negedge clk);
        chk("t4_nack_busy", 8'h00, {7'd0, busy});
        chk("t4_nack_sda",  8'h01, {7'd0, sda});
        i2c_stop();

        // Repeated STARTs: pointer 0x01 (no conversion), partial read, then a new conversion.
        s0 = n_strobe;
        i2c_start(); wr("t5_a", 8'hA4, 1'b0); wr("t5_p1", 8'h01, 1'b0);
        i2c_start(); wr("t5_ra", 8'hA5, 1'b0);
        rd("t5_rd1", 8'h7F, 1'b1); rd("t5_rd2", 8'hA9, 1'b1); rd("t5_rd3", 8'h40, 1'b0);
        stick_x = 8'h5A;
        i2c_start(); wr("t5_b", 8'hA4, 1'b0); wr("t5_p0", 8'h00, 1'b0);
        chk("t5_strobe", 8'd1, 8'(n_strobe - s0));
        i2c_start(); wr("t5_rb", 8'hA5, 1'b0); rd("t5_new", 8'h5A, 1'b0); i2c_stop();

        // STOP in the middle of a data byte.
        i2c_start(); wr("t6_a", 8'hA4, 1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        chk("t6_busy_mid", 8'h01, {7'd0, busy});
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("t6_busy", 8'h00, {7'd0, busy});
        chk("t6_sda",  8'h01, {7'd0, sda});

        // Wrong address: no ACK, idle after the address byte, trailing data ignored.
        s0 = n_strobe;
        watch_low = 1'b1;
        i2c_start();
        chk("t7_busy_addr", 8'h01, {7'd0, busy});
        wr("t7_nack_addr", 8'hA6, 1'b1);
        chk("t7_busy_after", 8'h00, {7'd0, busy});
        wr("t7_nack_data", 8'h00, 1'b1);
        watch_low = 1'b0;
        i2c_stop();
        chk("t7_sda_low_cycles", 8'd0, 8'(n_low));
        chk("t7_strobe", 8'd0, 8'(n_strobe - s0));

        // Reset while the responder drives a 0 data bit.
        stick_x = 8'h00;
        i2c_start(); wr("t8_a", 8'hA4, 1'b0); wr("t8_p", 8'h00, 1'b0);
        i2c_start(); wr("t8_ra", 8'hA5, 1'b0);
        chk("t8_sda_driven", 8'h00, {7'd0, sda});
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("t8_rst_sda",  8'h01, {7'd0, sda});
        chk("t8_rst_busy", 8'h00, {7'd0, busy});
        chk("t8_rst_init", 8'h00, {7'd0, init_done});
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        i2c_stop();
        i2c_start(); wr("t8_after_a", 8'hA5, 1'b0); rd("t8_after_rd", 8'hFF, 1'b0); i2c_stop();

        tb_done = 1'b1;
        for (int i = 0; i < 200 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_drain actual=pending required=drained");
            $fatal(1, "monitor did not drain");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
